// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operand/opcode request side and result/flags response side.
interface seq_alu_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] z;
    logic         co;
    logic         zero;
    logic         ovf;
    logic         neg;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, z, co, zero, ovf, neg
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, z, co, zero, ovf, neg
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops, N-step shift-add multiply and
// restoring divide, registered result plus zero/carry/overflow/negative flags.
module seq_alu #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   z_q, z_d;
    logic           co_q, co_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     add_w, sub_w;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_sh, div_diff;
    logic           div_ge;
    logic [2*N-1:0] div_acc_next;
    logic [N-1:0]   rem_next;
    logic           last_step;

    assign add_w = {1'b0, bus.x} + {1'b0, bus.y};
    assign sub_w = {1'b0, bus.x} - {1'b0, bus.y};

    // Multiply: low half of acc starts as the multiplier and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[N-1:1]};

    // Divide: low half of acc starts as the dividend and fills with quotient bits.
    // A zero divisor naturally yields all-ones quotient and remainder == x.
    assign div_sh       = {rem_q, acc_q[N-1]};
    assign div_ge       = div_sh >= {1'b0, b_q};
    assign div_diff     = div_sh - {1'b0, b_q};
    assign div_acc_next = {acc_q[2*N-1:N], acc_q[N-2:0], div_ge};
    assign rem_next     = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];

    assign last_step = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.op[1:0];
                    if (bus.op[3:2] == 2'b10) begin
                        state_d = BUSY;
                        a_d     = bus.x;
                        b_d     = bus.y;
                        acc_d   = {{N{1'b0}}, (bus.op[1] ? bus.x : bus.y)};
                        rem_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        z_d     = '0;
                        co_d    = 1'b0;
                        ovf_d   = 1'b0;
                        case (bus.op)
                            4'b0000: begin
                                z_d   = add_w[N-1:0];
                                co_d  = add_w[N];
                                ovf_d = (bus.x[N-1] == bus.y[N-1]) && (add_w[N-1] != bus.x[N-1]);
                            end
                            4'b0001: begin
                                z_d   = sub_w[N-1:0];
                                co_d  = sub_w[N];
                                ovf_d = (bus.x[N-1] != bus.y[N-1]) && (sub_w[N-1] != bus.x[N-1]);
                            end
                            4'b0010: z_d = bus.x & bus.y;
                            4'b0011: z_d = bus.x | bus.y;
                            4'b0100: z_d = bus.x ^ bus.y;
                            4'b0101: z_d = {{(N-1){1'b0}}, ($signed(bus.x) < $signed(bus.y))};
                            4'b0110: z_d = {{(N-1){1'b0}}, (bus.x < bus.y)};
                            4'b0111: z_d = ~(bus.x | bus.y);
                            default: z_d = '0;
                        endcase
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    acc_d = div_acc_next;
                    rem_d = rem_next;
                end else begin
                    acc_d = mul_next;
                end
                if (last_step) begin
                    state_d = DONE;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    case (op_q)
                        2'b00:   z_d = mul_next[N-1:0];
                        2'b01:   z_d = mul_next[2*N-1:N];
                        2'b10:   z_d = div_acc_next[N-1:0];
                        default: z_d = rem_next;
                    endcase
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.z         = z_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = (z_q == '0);
    assign bus.neg       = z_q[N-1];
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the multi-cycle processor datapath.
- Executes single-cycle logic and arithmetic ops, plus iterative unsigned multiply and divide.
- Registers the result together with zero, carry, overflow and negative flags.
- Sits between the register-file read stage and writeback, with valid/ready on both sides.

Parameters:
- N, 32, operand and result width (N >= 4).
- CW, 6, width of the internal iteration counter; must satisfy 2^CW > N.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept a new operation.
- op  in  4  opcode, sampled on accept.
- x  in  N  operand A, sampled on accept.
- y  in  N  operand B, sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- z  out  N  result.
- co  out  1  carry (ADD) or borrow (SUB).
- zero  out  1  z == 0.
- ovf  out  1  signed overflow (ADD/SUB only).
- neg  out  1  z[N-1].

Behaviour:
- Opcodes:
  - 0000 ADD: {co,z} = x+y.
  - 0001 SUB: {co,z} = x-y, so co=1 iff x<y unsigned.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLT: z = 1 if signed x<y, else 0.
  - 0110 SLTU: unsigned compare, same encoding.
  - 0111 NOR.
  - 1000 MUL: low N bits of the unsigned product.
  - 1001 MULHU: high N bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
  - 1100-1111: z=0, all other flags 0 (so zero=1).
- Flags:
  - co and ovf are 0 for all ops except ADD/SUB.
  - ovf: ADD sets it when both operands have the same sign and the result sign differs; SUB sets it when operand signs differ and the result sign differs from x.
  - zero and neg are always derived from the final registered z.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - An operation is accepted when in_valid && in_ready.
- Single-cycle ops (0000-0111, 1100-1111):
  - Result computed on the accept cycle and registered.
  - Transition IDLE->DONE; out_valid=1 on the next cycle (latency 1).
- Iterative ops (1000-1011):
  - Transition IDLE->BUSY; operands latched and counter cleared.
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, exactly N steps.
  - Transition BUSY->DONE on the cycle the counter reaches N-1.
  - out_valid asserts N+1 cycles after accept.
  - The 2N-bit product accumulator and the N-bit remainder are internal.
- Divide by zero:
  - No trap; still takes N+1 cycles.
  - DIVU gives all ones; REMU gives x.
- DONE:
  - z and flags are held stable while out_valid=1 && out_ready=0.
  - When out_ready=1: DONE->IDLE, out_valid deasserts next cycle, in_ready rises next cycle.
  - No accept is possible in the same cycle as the output handshake; minimum issue interval is 2 cycles.
- Inputs are ignored outside IDLE. x, y and op changing during BUSY do not affect the result.
- Reset (asynchronous, any state including mid-BUSY):
  - state=IDLE, in_ready=1, out_valid=0, z=0, co=0, ovf=0, neg=0, zero=1.
  - Counter and accumulators are cleared.
  - Any in-flight result is discarded.
- Width rules: SLT/SLTU produce a result zero-extended to N. Shifts inside MUL/DIV are logical.

Test Plan:
- ADD and SUB flags:
  - ADD x=0xFFFFFFFF, y=1 -> z=0, co=1, zero=1, ovf=0; out_valid one cycle after accept.
  - ADD x=0x7FFFFFFF, y=1 -> z=0x80000000, ovf=1, neg=1.
  - SUB x=3, y=5 -> z=0xFFFFFFFE, co=1, neg=1.
- Compares: SLT x=0xFFFFFFFF, y=1 -> z=1; SLTU with the same operands -> z=0, zero=1.
- Multiply:
  - MUL x=0x10000, y=0x10000 -> z=0, zero=1, out_valid at accept+33.
  - MULHU on the same operands -> z=1.
  - in_ready=0 throughout BUSY.
- Divide:
  - DIVU x=100, y=7 -> z=14; REMU -> z=2.
  - DIVU x=5, y=0 -> z=0xFFFFFFFF; REMU x=5, y=0 -> z=5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> z and flags stable, in_valid ignored; raise out_ready -> IDLE next cycle, new op accepted.
- Reset mid-operation: assert rst 10 cycles into a DIVU -> immediately out_valid=0, in_ready=1, zero=1; after release an ADD 2+2 returns z=4 one cycle after accept.
